// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : axi_wr_arbiter
// Description : N:1 AXI4 write arbiter; round-robin AW, in-order W, ID-routed B.
// Revision    : 1.0
// =============================================================================
module axi_wr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int SEL_W      = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4,
    parameter int WQ_DEPTH   = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_awaddr,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]    s_awid,
    input  logic [NUM_PORTS*8-1:0]           s_awlen,
    input  logic [NUM_PORTS*3-1:0]           s_awsize,
    input  logic [NUM_PORTS*2-1:0]           s_awburst,
    input  logic [NUM_PORTS-1:0]             s_awvalid,
    output logic [NUM_PORTS-1:0]             s_awready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [NUM_PORTS-1:0]             s_wlast,
    input  logic [NUM_PORTS-1:0]             s_wvalid,
    output logic [NUM_PORTS-1:0]             s_wready,
    output logic [1:0]                       s_bresp,
    output logic [ID_WIDTH-1:0]              s_bid,
    output logic [NUM_PORTS-1:0]             s_bvalid,
    input  logic [NUM_PORTS-1:0]             s_bready,
    output logic [ADDR_WIDTH-1:0]            m_awaddr,
    output logic [ID_WIDTH+SEL_W-1:0]        m_awid,
    output logic [7:0]                       m_awlen,
    output logic [2:0]                       m_awsize,
    output logic [1:0]                       m_awburst,
    output logic                             m_awvalid,
    input  logic                             m_awready,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_wstrb,
    output logic                             m_wlast,
    output logic                             m_wvalid,
    input  logic                             m_wready,
    input  logic [1:0]                       m_bresp,
    input  logic [ID_WIDTH+SEL_W-1:0]        m_bid,
    input  logic                             m_bvalid,
    output logic                             m_bready
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_ptr_w  = $clog2(WQ_DEPTH);

    logic [ADDR_WIDTH-1:0]     r_awaddr;
    logic [ID_WIDTH+SEL_W-1:0] r_awid;
    logic [7:0]                r_awlen;
    logic [2:0]                r_awsize;
    logic [1:0]                r_awburst;
    logic                      r_awvalid;
    logic [SEL_W-1:0]          r_rr_ptr;
    logic [SEL_W-1:0]          r_fifo [WQ_DEPTH];
    logic [c_ptr_w:0]          r_wr_ptr;
    logic [c_ptr_w:0]          r_rd_ptr;

    logic [SEL_W-1:0]          w_grant;
    logic                      w_any;
    logic [SEL_W-1:0]          w_rr_next;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_capture;
    logic [SEL_W-1:0]          w_head;
    logic [SEL_W-1:0]          w_bport;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_head  = r_fifo[r_rd_ptr[c_ptr_w-1:0]];

    // Scan from the farthest offset down so the nearest requester at/after the pointer wins.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (s_awvalid[(int'(r_rr_ptr) + k) % NUM_PORTS]) begin
                w_grant = SEL_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
                w_any   = 1'b1;
            end
        end
    end

    assign w_rr_next = (int'(w_grant) == NUM_PORTS - 1) ? '0 : w_grant + 1'b1;

    // A completing burst frees its slot in the same cycle, so a full queue can still accept.
    assign w_pop     = m_wvalid & m_wready & m_wlast;
    assign w_capture = rst_n & w_any & (~r_awvalid | m_awready) & (~w_full | w_pop);

    always_comb begin
        s_awready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_awready[i] = w_capture & (w_grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_awvalid <= 1'b0;
            r_rr_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_capture) begin
                r_awaddr  <= s_awaddr[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
                r_awid    <= {w_grant, s_awid[int'(w_grant)*ID_WIDTH +: ID_WIDTH]};
                r_awlen   <= s_awlen[int'(w_grant)*8 +: 8];
                r_awsize  <= s_awsize[int'(w_grant)*3 +: 3];
                r_awburst <= s_awburst[int'(w_grant)*2 +: 2];
                r_awvalid <= 1'b1;
                r_rr_ptr  <= w_rr_next;
                r_fifo[r_wr_ptr[c_ptr_w-1:0]] <= w_grant;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end else if (m_awready) begin
                r_awvalid <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign m_awaddr  = r_awaddr;
    assign m_awid    = r_awid;
    assign m_awlen   = r_awlen;
    assign m_awsize  = r_awsize;
    assign m_awburst = r_awburst;
    assign m_awvalid = r_awvalid;

    always_comb begin
        m_wvalid = 1'b0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = 1'b0;
        s_wready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_empty && (w_head == SEL_W'(i))) begin
                m_wvalid    = s_wvalid[i];
                m_wdata     = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_wstrb     = s_wstrb[i*c_strb_w +: c_strb_w];
                m_wlast     = s_wlast[i];
                s_wready[i] = m_wready;
            end
        end
    end

    // Responses carrying an index with no matching port are accepted and dropped.
    assign w_bport = m_bid[ID_WIDTH +: SEL_W];

    always_comb begin
        s_bvalid = '0;
        m_bready = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_bport == SEL_W'(i)) begin
                s_bvalid[i] = m_bvalid;
                m_bready    = s_bready[i];
            end
        end
    end

    assign s_bid   = m_bid[ID_WIDTH-1:0];
    assign s_bresp = m_bresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_axi_wr_arbiter
// Description : Directed self-checking bench for axi_wr_arbiter.
// Revision    : 1.0
// =============================================================================
module tb_axi_wr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic              clk;
    logic              rst_n;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*IW-1:0]   s_awid;
    logic [N*8-1:0]    s_awlen;
    logic [N*3-1:0]    s_awsize;
    logic [N*2-1:0]    s_awburst;
    logic [N-1:0]      s_awvalid;
    logic [N-1:0]      s_awready;
    logic [N*DW-1:0]   s_wdata;
    logic [N*DW/8-1:0] s_wstrb;
    logic [N-1:0]      s_wlast;
    logic [N-1:0]      s_wvalid;
    logic [N-1:0]      s_wready;
    logic [1:0]        s_bresp;
    logic [IW-1:0]     s_bid;
    logic [N-1:0]      s_bvalid;
    logic [N-1:0]      s_bready;
    logic [AW-1:0]     m_awaddr;
    logic [IW+1:0]     m_awid;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_awvalid;
    logic              m_awready;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_wlast;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic [IW+1:0]     m_bid;
    logic              m_bvalid;
    logic              m_bready;

    int n_vec = 0;
    int n_err = 0;

    axi_wr_arbiter #(
        .NUM_PORTS (N), .SEL_W (2), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
        .ID_WIDTH  (IW), .WQ_DEPTH (8)
    ) u_dut (
        .clk (clk), .rst_n (rst_n),
        .s_awaddr (s_awaddr), .s_awid (s_awid), .s_awlen (s_awlen),
        .s_awsize (s_awsize), .s_awburst (s_awburst),
        .s_awvalid (s_awvalid), .s_awready (s_awready),
        .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_wlast (s_wlast),
        .s_wvalid (s_wvalid), .s_wready (s_wready),
        .s_bresp (s_bresp), .s_bid (s_bid), .s_bvalid (s_bvalid), .s_bready (s_bready),
        .m_awaddr (m_awaddr), .m_awid (m_awid), .m_awlen (m_awlen),
        .m_awsize (m_awsize), .m_awburst (m_awburst),
        .m_awvalid (m_awvalid), .m_awready (m_awready),
        .m_wdata (m_wdata), .m_wstrb (m_wstrb), .m_wlast (m_wlast),
        .m_wvalid (m_wvalid), .m_wready (m_wready),
        .m_bresp (m_bresp), .m_bid (m_bid), .m_bvalid (m_bvalid), .m_bready (m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n     = 1'b0;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_wlast   = '0;
        s_bready  = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int beat;
    int cyc;

    initial begin
        rst_n     = 1'b0;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_wlast   = '0;
        s_wdata   = '0;
        s_wstrb   = '1;
        s_bready  = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_awburst = '0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bid     = '0;
        m_bresp   = '0;
        for (int i = 0; i < N; i++) begin
            s_awaddr[i*AW +: AW] = 32'h1000 * (i + 1);
            s_awid[i*IW +: IW]   = IW'(i + 4);
        end

        // Reset state, with every port requesting
        s_awvalid = 4'b1111;
        m_awready = 1'b1;
        tick();
        check_eq("rst_awvalid", m_awvalid, 0);
        check_eq("rst_awready", s_awready, 0);
        check_eq("rst_wvalid", m_wvalid, 0);
        check_eq("rst_awid", m_awid, 0);
        check_eq("rst_awaddr", m_awaddr, 0);
        tick();
        rst_n = 1'b1;

        // Round-robin order 0,1,2,3,0,1 at one AW per cycle
        #1;
        check_eq("rr_first_grant", s_awready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("rr_awvalid", m_awvalid, 1);
            check_eq("rr_awid", m_awid, {2'(k % 4), 4'((k % 4) + 4)});
            check_eq("rr_awaddr", m_awaddr, 32'h1000 * ((k % 4) + 1));
            check_eq("rr_next_grant", s_awready, 4'b0001 << ((k + 1) % 4));
        end

        // Port 2, 4-beat burst with m_wready toggling
        reset_dut();
        m_awready = 1'b1;
        s_awlen[2*8 +: 8] = 8'd3;
        s_awvalid = 4'b0100;
        #1;
        check_eq("b2_awready", s_awready, 4'b0100);
        tick();
        s_awvalid = '0;
        check_eq("b2_awlen", m_awlen, 3);
        check_eq("b2_awid", m_awid, {2'd2, 4'd6});
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 20) begin
            m_wready = (cyc % 2 == 0);
            s_wvalid = 4'b0100;
            s_wdata[2*DW +: DW] = 32'hA0 + beat;
            s_wlast  = (beat == 3) ? 4'b0100 : 4'b0000;
            #1;
            check_eq("b2_wvalid", m_wvalid, 1);
            check_eq("b2_wready", s_wready, {1'b0, m_wready, 2'b00});
            check_eq("b2_wdata", m_wdata, 32'hA0 + beat);
            check_eq("b2_wlast", m_wlast, beat == 3);
            tick();
            if (m_wready) beat++;
            cyc++;
        end
        check_eq("b2_beats", beat, 4);
        check_eq("b2_cycles", cyc, 7);
        #1;
        check_eq("b2_empty_wvalid", m_wvalid, 0);
        check_eq("b2_empty_wready", s_wready, 0);

        // Port 1 W arriving five cycles ahead of its AW
        reset_dut();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        s_wvalid  = 4'b0010;
        s_wlast   = 4'b0010;
        s_wdata[1*DW +: DW] = 32'hDEAD0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("early_wready", s_wready, 0);
            check_eq("early_wvalid", m_wvalid, 0);
            tick();
        end
        s_awvalid = 4'b0010;
        #1;
        check_eq("early_awready", s_awready, 4'b0010);
        check_eq("early_wready_cap", s_wready, 0);
        tick();
        s_awvalid = '0;
        #1;
        check_eq("early_wready_go", s_wready, 4'b0010);
        check_eq("early_wvalid_go", m_wvalid, 1);
        check_eq("early_wdata", m_wdata, 32'hDEAD0001);
        check_eq("early_wlast", m_wlast, 1);
        tick();
        #1;
        check_eq("early_popped", s_wready, 0);
        s_wvalid = '0;
        s_wlast  = '0;

        // Order FIFO fill to 8, then release one slot
        reset_dut();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        s_awvalid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("fill_awready", s_awready, 4'b0001);
            tick();
        end
        #1;
        check_eq("full_awready", s_awready, 0);
        tick();
        check_eq("full_awready2", s_awready, 0);
        check_eq("full_awvalid_drained", m_awvalid, 0);
        s_wvalid = 4'b0001;
        s_wlast  = 4'b0001;
        #1;
        check_eq("full_pop_wready", s_wready, 4'b0001);
        check_eq("full_pop_awready", s_awready, 4'b0001);
        tick();
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        check_eq("full_again_awready", s_awready, 0);
        check_eq("full_again_awvalid", m_awvalid, 1);

        // B routing by prepended port index
        s_awvalid = '0;
        m_bid     = {2'd3, 4'hA};
        m_bresp   = 2'b10;
        m_bvalid  = 1'b1;
        s_bready  = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("b3_bvalid", s_bvalid, 4'b1000);
            check_eq("b3_bid", s_bid, 4'hA);
            check_eq("b3_bready_hold", m_bready, 0);
            check_eq("b3_bresp", s_bresp, 2'b10);
            tick();
        end
        s_bready = 4'b1000;
        #1;
        check_eq("b3_bready_go", m_bready, 1);
        tick();
        m_bid    = {2'd1, 4'h5};
        m_bresp  = 2'b00;
        s_bready = 4'b1101;
        #1;
        check_eq("b1_bvalid", s_bvalid, 4'b0010);
        check_eq("b1_bid", s_bid, 4'h5);
        check_eq("b1_bready", m_bready, 0);
        s_bready = 4'b0010;
        #1;
        check_eq("b1_bready_go", m_bready, 1);
        tick();
        m_bvalid = 1'b0;
        #1;
        check_eq("b_idle_bvalid", s_bvalid, 0);

        // Asynchronous reset with an AW pending downstream
        reset_dut();
        m_awready = 1'b0;
        s_awvalid = 4'b0100;
        tick();
        check_eq("mid_awvalid_pre", m_awvalid, 1);
        check_eq("mid_hold_awready", s_awready, 0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_awvalid", m_awvalid, 0);
        check_eq("mid_rst_awready", s_awready, 0);
        check_eq("mid_rst_awid", m_awid, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        s_awvalid = 4'b1111;
        s_wvalid  = 4'b1111;
        m_wready  = 1'b1;
        #1;
        check_eq("post_rst_rr", s_awready, 4'b0001);
        check_eq("post_rst_wvalid", m_wvalid, 0);
        check_eq("post_rst_wready", s_wready, 0);
        s_awvalid = '0;
        s_wvalid  = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
